dcache_flush_ctrl: RTL and testbench
====================================

# dcache_flush_ctrl

Sequencer for one `dcache_line` on a miss. It writes the old line back to memory when the line is dirty, then refills the whole line from memory through the line's flush port. It sits between `dcache_line` (the flush_* and line_* signals) and the single-word external memory bus. It stalls the CPU-side requester with `flush_busy` until the line holds the requested section.

## Interface
- DATABITS, 32, word width
- ADDRBITS, 32, byte address width
- CACHEADDRBITS, 5, log2 words per line; the line holds 2^CACHEADDRBITS words
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- miss_req  in  1  CPU access pending on this line (dcache_rdreq|dcache_wrreq)
- miss_addr  in  ADDRBITS  byte address of the pending access
- line_miss  in  1  from the line: section mismatch, or line never filled
- line_dirty  in  1  from the line
- line_memory_section  in  ADDRBITS  section base currently held by the line (low CACHEADDRBITS+2 bits zero)
- line_out  in  DATABITS  line read data; valid one cycle after `flush_addr` is applied
- flush_mode  out  1  to the line
- flush_we  out  1  to the line
- flush_addr  out  ADDRBITS  to the line
- flush_in  out  DATABITS  to the line
- mem_addr  out  ADDRBITS  word-aligned byte address
- mem_rdreq  out  1  read request; held until mem_ack
- mem_wrreq  out  1  write request; held until mem_ack
- mem_out  out  DATABITS  write data
- mem_in  in  DATABITS  read data; valid with mem_ack
- mem_ack  in  1  completes the current request; may arrive in the same cycle as the request
- flush_busy  out  1  controller not in IDLE
- flush_done  out  1  one-cycle pulse when the refill is complete

## Operation
- States: IDLE, WB_ADDR, WB_REQ, FILL_REQ, FILL_WR, DONE.
- Word index `idx` is CACHEADDRBITS wide.
- `sec` = latched miss_addr[ADDRBITS-1:CACHEADDRBITS+2].
- `old` = latched line_memory_section.
- **IDLE**
  - Start condition: miss_req & line_miss.
  - On start: latch sec and old, set idx=0.
  - If line_dirty, go to WB_ADDR; otherwise go to FILL_REQ.
  - miss_req without line_miss is ignored.
- **WB_ADDR**
  - Drive flush_addr = old | idx<<2, flush_we=0.
  - Go to WB_REQ.
- **WB_REQ**
  - Entry cycle: capture line_out into the write-data register.
  - Drive mem_wrreq=1, mem_addr = old | idx<<2, mem_out = captured data, held until mem_ack.
  - On mem_ack: idx++. If idx was all-ones (wrap to 0), go to FILL_REQ; otherwise go to WB_ADDR.
- **FILL_REQ**
  - Drive mem_rdreq=1, mem_addr = {sec, idx, 2'b00} until mem_ack.
  - On mem_ack: capture mem_in, go to FILL_WR.
- **FILL_WR**
  - Drive flush_we=1, flush_addr = {sec, idx, 2'b00}, flush_in = captured data.
  - idx++. On wrap, go to DONE; otherwise go to FILL_REQ.
  - Each write also sets the line's section to sec and clears its dirty bit.
- **DONE**
  - flush_done=1 for one cycle, then return to IDLE.
- flush_mode=1 in WB_ADDR, WB_REQ, FILL_REQ and FILL_WR only.
- mem_rdreq and mem_wrreq are never both 1. At most one memory request is outstanding.
- miss_req and miss_addr are sampled only in IDLE; changes during a sequence are ignored.

## Timing
- Reset values:
  - State IDLE, idx=0, all data and address registers 0.
  - Every output 0: flush_mode, flush_we, flush_addr, flush_in, mem_addr, mem_rdreq, mem_wrreq, mem_out, flush_busy, flush_done.
  - Optional counters 0.
- Reset asserted mid-sequence returns to IDLE immediately and drops all requests. The line's contents are then undefined to the CPU, and the next miss restarts from scratch.
- flush_busy rises the cycle after the start condition and falls the cycle after DONE.
- With mem_ack in the same cycle as each request (zero wait states):
  - Clean miss: 2·2^CACHEADDRBITS cycles + 1 (DONE).
  - Dirty miss: 4·2^CACHEADDRBITS + 1.
  - Each wait cycle on mem_ack adds one cycle per word.
- All outputs are registered or decoded from state and registers. There is no combinational path from mem_ack or miss_req to any output.

## Configuration
- DCACHE_FLUSH_PERF_EN defined:
  - Adds outputs perf_miss_cnt (32 bits) and perf_wb_cnt (32 bits).
  - perf_miss_cnt increments on every IDLE start; perf_wb_cnt increments on every dirty start.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and the counters are absent. All other behaviour is identical.

## Test plan
- **Clean first fill.** CACHEADDRBITS=2. After reset (line_miss=1, line_dirty=0), miss_addr=0x1000, zero-wait mem returns 0xA0..0xA3.
  - Exactly 4 mem_rdreq to 0x1000, 0x1004, 0x1008, 0x100C.
  - 4 flush_we with flush_in 0xA0..0xA3.
  - No mem_wrreq; flush_done in cycle 9 after start.
- **Dirty eviction.** Line holds 0x2000 with data 0xB0..0xB3 and line_dirty=1; miss_addr=0x3004.
  - 4 mem_wrreq to 0x2000..0x200C with mem_out 0xB0..0xB3.
  - Then 4 reads from 0x3000..0x300C; 17 cycles total.
- **Wait states.** mem_ack delayed 3 cycles per request.
  - mem_rdreq and mem_addr held stable while waiting.
  - Clean-miss total = 4·(1+3)+4+1 = 21.
- **Reset mid-fill.** reset_n pulled low during the 2nd FILL_REQ.
  - All outputs 0 asynchronously; state IDLE.
  - A new miss restarts at idx=0.
- **Ignored inputs.**
  - miss_req=1 with line_miss=0 in IDLE: no state change.
  - miss_addr changed during a fill: addresses still use the latched sec.
- **Perf counters** (DCACHE_FLUSH_PERF_EN). Run the clean fill then the dirty eviction scenarios: perf_miss_cnt=2, perf_wb_cnt=1. A forced value 0xFFFFFFFF stays saturated on the next miss.

Source files
------------

// File: rtl/dcache_flush_ctrl_if.sv
// Bus bundle between the flush controller, its dcache_line and the single-word memory bus.
// master = the flush controller, slave = line/memory/requester side.
interface dcache_flush_ctrl_if #(
   parameter int DATABITS = 32,
   parameter int ADDRBITS = 32
);
   logic                miss_req;
   logic [ADDRBITS-1:0] miss_addr;
   logic                line_miss;
   logic                line_dirty;
   logic [ADDRBITS-1:0] line_memory_section;
   logic [DATABITS-1:0] line_out;
   logic                flush_mode;
   logic                flush_we;
   logic [ADDRBITS-1:0] flush_addr;
   logic [DATABITS-1:0] flush_in;
   logic [ADDRBITS-1:0] mem_addr;
   logic                mem_rdreq;
   logic                mem_wrreq;
   logic [DATABITS-1:0] mem_out;
   logic [DATABITS-1:0] mem_in;
   logic                mem_ack;
   logic                flush_busy;
   logic                flush_done;

   modport master (
      input  miss_req, miss_addr, line_miss, line_dirty, line_memory_section, line_out,
             mem_in, mem_ack,
      output flush_mode, flush_we, flush_addr, flush_in, mem_addr, mem_rdreq, mem_wrreq,
             mem_out, flush_busy, flush_done
   );

   modport slave (
      output miss_req, miss_addr, line_miss, line_dirty, line_memory_section, line_out,
             mem_in, mem_ack,
      input  flush_mode, flush_we, flush_addr, flush_in, mem_addr, mem_rdreq, mem_wrreq,
             mem_out, flush_busy, flush_done
   );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// Miss sequencer for one dcache_line: optional dirty write-back, then full-line refill.
// Define DCACHE_FLUSH_PERF_EN to add saturating miss / write-back counters.
module dcache_flush_ctrl #(
   parameter int DATABITS      = 32,
   parameter int ADDRBITS      = 32,
   parameter int CACHEADDRBITS = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   dcache_flush_ctrl_if.master bus
`ifdef DCACHE_FLUSH_PERF_EN
   ,
   output logic [31:0]         perf_miss_cnt_o,
   output logic [31:0]         perf_wb_cnt_o
`endif
);
   localparam int SECBITS = ADDRBITS - CACHEADDRBITS - 2;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WB_ADDR  = 3'd1;
   localparam logic [2:0] S_WB_REQ   = 3'd2;
   localparam logic [2:0] S_FILL_REQ = 3'd3;
   localparam logic [2:0] S_FILL_WR  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [CACHEADDRBITS-1:0] idx_q, idx_d;
   logic [SECBITS-1:0]       sec_q, sec_d;
   logic [ADDRBITS-1:0]      old_q, old_d;
   logic [DATABITS-1:0]      wdata_q, wdata_d;
   logic [DATABITS-1:0]      rdata_q, rdata_d;
   logic                     entry_q, entry_d;

   logic                start;
   logic                idx_last;
   logic [ADDRBITS-1:0] idx_off;
   logic [ADDRBITS-1:0] wb_addr;
   logic [ADDRBITS-1:0] fill_addr;
   logic                unused_addr_bits;

   assign start            = (state_q == S_IDLE) && bus.miss_req && bus.line_miss;
   assign idx_last         = &idx_q;
   assign idx_off          = {{SECBITS{1'b0}}, idx_q, 2'b00};
   assign wb_addr          = old_q | idx_off;
   assign fill_addr        = {sec_q, idx_q, 2'b00};
   assign unused_addr_bits = ^bus.miss_addr[CACHEADDRBITS+1:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sec_d   = sec_q;
      old_d   = old_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      entry_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sec_d   = bus.miss_addr[ADDRBITS-1:CACHEADDRBITS+2];
               old_d   = bus.line_memory_section;
               idx_d   = '0;
               state_d = bus.line_dirty ? S_WB_ADDR : S_FILL_REQ;
            end
         end
         S_WB_ADDR: begin
            state_d = S_WB_REQ;
            entry_d = 1'b1;
         end
         S_WB_REQ: begin
            if (entry_q) wdata_d = bus.line_out;
            if (bus.mem_ack) begin
               idx_d   = idx_q + 1'b1;
               state_d = idx_last ? S_FILL_REQ : S_WB_ADDR;
            end
         end
         S_FILL_REQ: begin
            if (bus.mem_ack) begin
               rdata_d = bus.mem_in;
               state_d = S_FILL_WR;
            end
         end
         S_FILL_WR: begin
            idx_d   = idx_q + 1'b1;
            state_d = idx_last ? S_DONE : S_FILL_REQ;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         sec_q   <= '0;
         old_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         entry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sec_q   <= sec_d;
         old_q   <= old_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         entry_q <= entry_d;
      end
   end

   // line_out is only valid in the first WB_REQ cycle; later cycles use the captured copy.
   assign bus.mem_out    = (state_q == S_WB_REQ) ? (entry_q ? bus.line_out : wdata_q) : '0;
   assign bus.mem_wrreq  = (state_q == S_WB_REQ);
   assign bus.mem_rdreq  = (state_q == S_FILL_REQ);
   assign bus.mem_addr   = (state_q == S_WB_REQ)   ? wb_addr :
                           (state_q == S_FILL_REQ) ? fill_addr : '0;
   assign bus.flush_mode = (state_q == S_WB_ADDR) || (state_q == S_WB_REQ) ||
                           (state_q == S_FILL_REQ) || (state_q == S_FILL_WR);
   assign bus.flush_we   = (state_q == S_FILL_WR);
   assign bus.flush_addr = ((state_q == S_WB_ADDR) || (state_q == S_WB_REQ)) ? wb_addr :
                           (state_q == S_FILL_WR) ? fill_addr : '0;
   assign bus.flush_in   = (state_q == S_FILL_WR) ? rdata_q : '0;
   assign bus.flush_busy = (state_q != S_IDLE);
   assign bus.flush_done = (state_q == S_DONE);

`ifdef DCACHE_FLUSH_PERF_EN
   logic [31:0] perf_miss_q, perf_miss_d;
   logic [31:0] perf_wb_q, perf_wb_d;

   assign perf_miss_d = (start && (perf_miss_q != 32'hFFFF_FFFF)) ? perf_miss_q + 32'd1 : perf_miss_q;
   assign perf_wb_d   = (start && bus.line_dirty && (perf_wb_q != 32'hFFFF_FFFF)) ?
                        perf_wb_q + 32'd1 : perf_wb_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_miss_q <= '0;
         perf_wb_q   <= '0;
      end else begin
         perf_miss_q <= perf_miss_d;
         perf_wb_q   <= perf_wb_d;
      end
   end

   assign perf_miss_cnt_o = perf_miss_q;
   assign perf_wb_cnt_o   = perf_wb_q;
`endif
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Scoreboard bench for dcache_flush_ctrl with a 4-word line, a behavioural line and memory.
// Counter checks are included when DCACHE_FLUSH_PERF_EN is defined.
module tb_dcache_flush_ctrl;
   localparam int CAB  = 2;
   localparam int K_RD = 0;
   localparam int K_WR = 1;
   localparam int K_LW = 2;
   localparam int K_DN = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   dcache_flush_ctrl_if #(.DATABITS(32), .ADDRBITS(32)) bus ();

`ifdef DCACHE_FLUSH_PERF_EN
   logic [31:0] perf_miss_cnt;
   logic [31:0] perf_wb_cnt;
`endif

   dcache_flush_ctrl #(.DATABITS(32), .ADDRBITS(32), .CACHEADDRBITS(CAB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef DCACHE_FLUSH_PERF_EN
      ,
      .perf_miss_cnt_o (perf_miss_cnt),
      .perf_wb_cnt_o   (perf_wb_cnt)
`endif
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          wait_states = 0;
   int          wcnt = 0;
   logic [31:0] fill_base = 32'h0;
   logic        preload = 1'b0;
   logic [31:0] preload_base = 32'h0;
   logic [31:0] line_data [4];
   exp_t        q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // memory: acks after wait_states idle cycles, read data = fill_base + word index
   assign bus.mem_ack = (bus.mem_rdreq || bus.mem_wrreq) && (wcnt >= wait_states);
   assign bus.mem_in  = bus.mem_rdreq ? fill_base + 32'(bus.mem_addr[3:2]) : 32'h0;

   always @(posedge clk) begin
      if (!reset_n)                          wcnt <= 0;
      else if (bus.mem_ack)                  wcnt <= 0;
      else if (bus.mem_rdreq || bus.mem_wrreq) wcnt <= wcnt + 1;
   end

   // line storage with one-cycle read latency
   always @(posedge clk) begin
      bus.line_out <= line_data[bus.flush_addr[3:2]];
      if (preload) begin
         for (int i = 0; i < 4; i++) line_data[i] <= preload_base + 32'(i);
      end else if (bus.flush_we) begin
         line_data[bus.flush_addr[3:2]] <= bus.flush_in;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic push_fill(input logic [31:0] base, input logic [31:0] dbase, input int total);
      for (int i = 0; i < 4; i++) begin
         push(K_RD, base + 32'(4 * i), dbase + 32'(i));
         push(K_LW, base + 32'(4 * i), dbase + 32'(i));
      end
      push(K_DN, 32'h0, 32'(total));
   endtask

   task automatic mon_event(input int k, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      $display("txn kind=%0d addr=%h data=%h cycle=%0d", k, a, d, cyc);
      if (q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_txn: got kind %0d addr %h, expected none", k, a);
      end else begin
         e = q.pop_front();
         check("txn_kind", 32'(k), 32'(e.kind));
         check("txn_addr", a, e.addr);
         check("txn_data", d, e.data);
      end
   endtask

   // monitor: compares every DUT-presented transaction against the scoreboard queue
   initial begin : monitor
      logic        pend;
      logic [31:0] pend_addr;
      logic        busy_prev;
      int          rise;
      pend = 1'b0;
      pend_addr = 32'h0;
      busy_prev = 1'b0;
      rise = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pend = 1'b0;
            busy_prev = 1'b0;
         end else begin
            if (pend) begin
               check("req_held", {31'b0, bus.mem_rdreq | bus.mem_wrreq}, 32'h1);
               check("addr_held", bus.mem_addr, pend_addr);
            end
            pend      = (bus.mem_rdreq || bus.mem_wrreq) && !bus.mem_ack;
            pend_addr = bus.mem_addr;
            check("req_exclusive", {31'b0, bus.mem_rdreq & bus.mem_wrreq}, 32'h0);
            if (bus.flush_busy && !busy_prev) rise = cyc;
            busy_prev = bus.flush_busy;
            if (bus.mem_rdreq && bus.mem_ack) mon_event(K_RD, bus.mem_addr, bus.mem_in);
            if (bus.mem_wrreq && bus.mem_ack) mon_event(K_WR, bus.mem_addr, bus.mem_out);
            if (bus.flush_we)                 mon_event(K_LW, bus.flush_addr, bus.flush_in);
            if (bus.flush_done)               mon_event(K_DN, 32'h0, 32'(cyc - rise + 1));
         end
      end
   end

   task automatic start_miss(input logic [31:0] addr);
      @(posedge clk);
      #2;
      bus.miss_addr = addr;
      bus.miss_req  = 1'b1;
      @(posedge clk);
      #2;
      bus.miss_req  = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.flush_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_in_time", {31'b0, seen}, 32'h1);
      @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, {26'b0, bus.flush_mode, bus.flush_we, bus.mem_rdreq, bus.mem_wrreq,
                             bus.flush_busy, bus.flush_done}, 32'h0);
      check({tag, "_flush_addr"}, bus.flush_addr, 32'h0);
      check({tag, "_flush_in"}, bus.flush_in, 32'h0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_mem_out"}, bus.mem_out, 32'h0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic found;
      reset_n                 = 1'b0;
      bus.miss_req            = 1'b0;
      bus.miss_addr           = 32'h0;
      bus.line_miss           = 1'b1;
      bus.line_dirty          = 1'b0;
      bus.line_memory_section = 32'h0;
      #1;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;

      // clean first fill
      wait_states = 0;
      fill_base   = 32'hA0;
      push_fill(32'h1000, 32'hA0, 9);
      start_miss(32'h1000);
      wait_done(100);

      // dirty eviction of section 0x2000
      @(posedge clk);
      #2;
      preload      = 1'b1;
      preload_base = 32'hB0;
      @(posedge clk);
      #2;
      preload                 = 1'b0;
      bus.line_dirty          = 1'b1;
      bus.line_memory_section = 32'h2000;
      fill_base               = 32'hC0;
      for (int i = 0; i < 4; i++) push(K_WR, 32'h2000 + 32'(4 * i), 32'hB0 + 32'(i));
      push_fill(32'h3000, 32'hC0, 17);
      start_miss(32'h3004);
      wait_done(100);
      bus.line_dirty          = 1'b0;
      bus.line_memory_section = 32'h3000;
`ifdef DCACHE_FLUSH_PERF_EN
      check("perf_miss_2", perf_miss_cnt, 32'd2);
      check("perf_wb_1", perf_wb_cnt, 32'd1);
`endif

      // three wait states per request; miss_addr moves mid-fill
      wait_states = 3;
      fill_base   = 32'hD0;
      push_fill(32'h4000, 32'hD0, 21);
      start_miss(32'h4008);
      bus.miss_addr = 32'h7000;
      wait_done(200);

      // miss_req without line_miss is ignored
      @(posedge clk);
      #2;
      bus.line_miss = 1'b0;
      bus.miss_req  = 1'b1;
      bus.miss_addr = 32'h9000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("ignored_busy", {31'b0, bus.flush_busy}, 32'h0);
      end
      @(posedge clk);
      #2;
      bus.miss_req  = 1'b0;
      bus.line_miss = 1'b1;

      // reset during the second FILL_REQ
      wait_states = 2;
      fill_base   = 32'hE0;
      push(K_RD, 32'h5000, 32'hE0);
      push(K_LW, 32'h5000, 32'hE0);
      start_miss(32'h5000);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.mem_rdreq && bus.mem_addr == 32'h5004) begin
            found = 1'b1;
            break;
         end
      end
      check("reached_fill2", {31'b0, found}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
`ifdef DCACHE_FLUSH_PERF_EN
      check("perf_miss_rst", perf_miss_cnt, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #2;
      reset_n     = 1'b1;
      wait_states = 0;
      push_fill(32'h5000, 32'hE0, 9);
      start_miss(32'h5000);
      wait_done(100);
`ifdef DCACHE_FLUSH_PERF_EN
      check("perf_miss_1", perf_miss_cnt, 32'd1);

      // saturation of a forced counter
      force dut.perf_miss_q = 32'hFFFF_FFFF;
      @(posedge clk);
      #2;
      release dut.perf_miss_q;
      fill_base = 32'hF0;
      push_fill(32'h6000, 32'hF0, 9);
      start_miss(32'h6000);
      wait_done(100);
      check("perf_miss_sat", perf_miss_cnt, 32'hFFFF_FFFF);
      check("perf_wb_0", perf_wb_cnt, 32'd0);
`endif

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
